multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter: WAIT_LIMIT, 8, maximum cycles spent in one memory state waiting for mem_ready before a bus error.
REQ-002 Port: clk  in  1  single clock; all state changes on rising edge.
REQ-003 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 Port: opcode  in  6  instruction[31:26], taken from the instruction register.
REQ-005 Port: mem_ready  in  1  memory completes the current access this cycle.
REQ-006 Port: pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a  out  1 each  standard multicycle MIPS datapath controls.
REQ-007 Port: alu_src_b, alu_op, pc_source  out  2 each  datapath mux and ALU selects.
REQ-008 Port: illegal  out  1  one-cycle pulse: unsupported opcode.
REQ-009 Port: bus_err  out  1  one-cycle pulse: memory wait exceeded WAIT_LIMIT.
REQ-010 Port: state  out  4  current state code, for debug.

Function
REQ-011 The block SHALL implement a registered-state FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, TRAP=12; codes 13-15 SHALL return to FETCH on the next edge.
REQ-012 Opcodes: R=000000, LW=100011, SW=101011, BEQ=000100, ADDI=001000, J=000010; matching SHALL be exact 6-bit equality.
REQ-013 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write and pc_write SHALL assert only in the cycle mem_ready=1, which advances to DECODE; otherwise the FSM stays in FETCH.
REQ-014 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00; next state LW/SW->MEMADR, R->EXEC, BEQ->BRANCH, ADDI->ADDIEX, J->JUMP, any other opcode->TRAP.
REQ-015 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00; LW->MEMRD, SW->MEMWR.
REQ-016 MEMRD: mem_read=1, iord=1; advance to MEMWB only on mem_ready=1. MEMWR: mem_write=1, iord=1; advance to FETCH only on mem_ready=1.
REQ-017 MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
REQ-018 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 -> ALUWB. ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
REQ-019 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01 -> FETCH.
REQ-020 ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00 -> ADDIWB. ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
REQ-021 JUMP: pc_write=1, pc_source=10 -> FETCH.
REQ-022 TRAP: all datapath controls 0 -> FETCH; illegal=1 for exactly the TRAP cycle when entered from DECODE.
REQ-023 Any output not listed for a state SHALL be 0 in that state.
REQ-024 A wait counter SHALL count consecutive cycles in FETCH, MEMRD or MEMWR with mem_ready=0, clearing on every state change or mem_ready=1.
REQ-025 When the counter reaches WAIT_LIMIT, the next edge SHALL go to TRAP with bus_err=1 for that TRAP cycle and all write-enables kept 0.
REQ-026 mem_ready=1 on the cycle the counter reaches WAIT_LIMIT SHALL take priority: normal advance, no bus_err.
REQ-027 Instruction latencies with mem_ready always 1: LW 5, SW 4, R 4, ADDI 4, BEQ 3, J 3 cycles.

Reset
REQ-028 rst_n=0 SHALL immediately force state=FETCH, wait counter=0 and every output to 0, independent of clk.
REQ-029 Reset asserted mid-instruction SHALL abandon it without emitting any write-enable; the first edge after rst_n rises SHALL evaluate FETCH normally.

Structure
REQ-030 Opcode constants, state codes and alu_op encodings SHALL live in shared package mips_ctrl_pkg.
REQ-031 Opcode decode SHALL use sub-module opcode_match (six equal6x2_1 comparisons producing a one-hot match vector).

Verification
REQ-032 LW with mem_ready=1 always: states 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in cycle 5.
REQ-033 SW with mem_ready low 3 cycles in MEMWR: state 5 held 4 cycles, mem_write=1 throughout, then FETCH; bus_err never asserted.
REQ-034 opcode=111111 in DECODE: next state 12, illegal=1 for one cycle, then state 0, no write-enables.
REQ-035 mem_ready held 0 in FETCH: after WAIT_LIMIT (8) cycles, state 12 with bus_err=1 for one cycle; ir_write never asserted.
REQ-036 rst_n pulsed low during MEMWR: outputs 0 at once, state=0; mem_write not asserted after release until a new SW reaches MEMWR.
REQ-037 BEQ then J back-to-back: states 0,1,8,0,1,11,0; pc_write_cond=1 only in state 8; pc_write=1 with pc_source=10 in state 11.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control unit:
// opcodes, state codes, mux/ALU selects and the control bundle.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam int M_R    = 0;
  localparam int M_LW   = 1;
  localparam int M_SW   = 2;
  localparam int M_BEQ  = 3;
  localparam int M_ADDI = 4;
  localparam int M_J    = 5;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFS = 2'b11;

  localparam logic [1:0] PC_ALU  = 2'b00;
  localparam logic [1:0] PC_OUT  = 2'b01;
  localparam logic [1:0] PC_JUMP = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
    logic       bus_err;
  } ctrl_t;

  function automatic logic equal6x2_1(
    input logic [5:0] a,
    input logic [5:0] b
  );
    return ~|(a ^ b);
  endfunction

endpackage

// File: rtl/opcode_match.sv
// One-hot opcode classifier: one exact 6-bit compare per
// supported instruction; an unsupported opcode yields all zeros.
module opcode_match
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output logic [5:0] match
);

  assign match[M_R]    = equal6x2_1(opcode, OP_R);
  assign match[M_LW]   = equal6x2_1(opcode, OP_LW);
  assign match[M_SW]   = equal6x2_1(opcode, OP_SW);
  assign match[M_BEQ]  = equal6x2_1(opcode, OP_BEQ);
  assign match[M_ADDI] = equal6x2_1(opcode, OP_ADDI);
  assign match[M_J]    = equal6x2_1(opcode, OP_J);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM with memory wait timeout,
// illegal-opcode trap and debug state output.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal,
  output logic       bus_err,
  output logic [3:0] state
);

  localparam int CW = $clog2(WAIT_LIMIT + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          bus_q, bus_d;
  logic [5:0]    match;
  logic          mem_state;
  logic          waiting;
  logic          timeout;
  ctrl_t         c;

  opcode_match u_match (
    .opcode (opcode),
    .match  (match)
  );

  assign mem_state = (state_q == S_FETCH) ||
                     (state_q == S_MEMRD) ||
                     (state_q == S_MEMWR);
  assign waiting   = mem_state && !mem_ready;
  // timeout fires on the WAIT_LIMIT-th consecutive idle cycle
  assign timeout   = waiting &&
                     (cnt_q == CW'(WAIT_LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      bus_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bus_q   <= bus_d;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    bus_d   = 1'b0;
    cnt_d   = '0;
    if (waiting && !timeout) begin
      cnt_d = cnt_q + CW'(1);
    end
    if (timeout) begin
      state_d = S_TRAP;
      bus_d   = 1'b1;
    end else begin
      case (state_q)
        S_FETCH:
          state_d = mem_ready ? S_DECODE : S_FETCH;
        S_DECODE: begin
          unique case (1'b1)
            match[M_LW],
            match[M_SW]:   state_d = S_MEMADR;
            match[M_R]:    state_d = S_EXEC;
            match[M_BEQ]:  state_d = S_BRANCH;
            match[M_ADDI]: state_d = S_ADDIEX;
            match[M_J]:    state_d = S_JUMP;
            default:       state_d = S_TRAP;
          endcase
        end
        S_MEMADR:
          state_d = match[M_SW] ? S_MEMWR : S_MEMRD;
        S_MEMRD:
          state_d = mem_ready ? S_MEMWB : S_MEMRD;
        S_MEMWR:
          state_d = mem_ready ? S_FETCH : S_MEMWR;
        S_EXEC:   state_d = S_ALUWB;
        S_ADDIEX: state_d = S_ADDIWB;
        default:  state_d = S_FETCH;
      endcase
    end
  end

  always_comb begin
    c = '0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          c.mem_read  = 1'b1;
          c.alu_src_b = SRCB_FOUR;
          c.alu_op    = ALU_ADD;
          c.pc_source = PC_ALU;
          c.ir_write  = mem_ready;
          c.pc_write  = mem_ready;
        end
        S_DECODE: begin
          c.alu_src_b = SRCB_BOFS;
          c.alu_op    = ALU_ADD;
        end
        S_MEMADR, S_ADDIEX: begin
          c.alu_src_a = 1'b1;
          c.alu_src_b = SRCB_IMM;
          c.alu_op    = ALU_ADD;
        end
        S_MEMRD: begin
          c.mem_read = 1'b1;
          c.iord     = 1'b1;
        end
        S_MEMWB: begin
          c.reg_write  = 1'b1;
          c.mem_to_reg = 1'b1;
        end
        S_MEMWR: begin
          c.mem_write = 1'b1;
          c.iord      = 1'b1;
        end
        S_EXEC: begin
          c.alu_src_a = 1'b1;
          c.alu_src_b = SRCB_REG;
          c.alu_op    = ALU_FUNCT;
        end
        S_ALUWB: begin
          c.reg_write = 1'b1;
          c.reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          c.alu_src_a     = 1'b1;
          c.alu_src_b     = SRCB_REG;
          c.alu_op        = ALU_SUB;
          c.pc_write_cond = 1'b1;
          c.pc_source     = PC_OUT;
        end
        S_ADDIWB:
          c.reg_write = 1'b1;
        S_JUMP: begin
          c.pc_write  = 1'b1;
          c.pc_source = PC_JUMP;
        end
        S_TRAP: begin
          c.illegal = !bus_q;
          c.bus_err = bus_q;
        end
        default: c = '0;
      endcase
    end
  end

  assign pc_write      = c.pc_write;
  assign pc_write_cond = c.pc_write_cond;
  assign iord          = c.iord;
  assign mem_read      = c.mem_read;
  assign mem_write     = c.mem_write;
  assign ir_write      = c.ir_write;
  assign mem_to_reg    = c.mem_to_reg;
  assign reg_dst       = c.reg_dst;
  assign reg_write     = c.reg_write;
  assign alu_src_a     = c.alu_src_a;
  assign alu_src_b     = c.alu_src_b;
  assign alu_op        = c.alu_op;
  assign pc_source     = c.pc_source;
  assign illegal       = c.illegal;
  assign bus_err       = c.bus_err;
  assign state         = state_q;

endmodule
